adaptive_bw_gearshift: RTL and testbench

Registered, parametrised bandwidth scaler between the DPLL loop filter and the DCO. It sequences through a ladder of gain "gears" driven by a dwell-qualified lock indication, rather than a binary lock switch. It widens loop gain (saturating left shift) during acquisition and narrows it in steps (arithmetic right shifts) as lock persists. On loss of lock it drops straight back to acquisition gear.

---
 rtl/dpll_pkg.sv | 16 +
 rtl/bw_sat_shift.sv | 46 ++++
 rtl/adaptive_bw_gearshift.sv | 139 +++++++++++++
 tb/tb_adaptive_bw_gearshift.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared DPLL definitions.
// Holds the default control-word width, the default gear count, the gear
// type sized from that count and the acquisition gear constant. Blocks that
// are instantiated with non-default sizes derive their own widths locally
// and cast ACQ_GEAR to their gear width.
package dpll_pkg;

    localparam int DEFAULT_W     = 16;
    localparam int DEFAULT_GEARS = 4;
    localparam int GEAR_WIDTH    = $clog2(DEFAULT_GEARS);

    typedef logic [GEAR_WIDTH-1:0] gear_t;

    localparam gear_t ACQ_GEAR = {GEAR_WIDTH{1'b0}};

endpackage

// File: rtl/bw_sat_shift.sv
// Combinational loop-gain scaler.
// Gear 0 doubles the sample with saturation to the signed range; gear k>=1
// divides it by 2^k with an arithmetic right shift (rounds toward -inf).
// Ports:
//   control_in  signed input sample, W bits
//   gear        gear selecting the scale factor, GW bits
//   scaled      signed scaled sample, W bits
//   sat         1 when the gear-0 doubling clipped
module bw_sat_shift
    import dpll_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int GW = GEAR_WIDTH
) (
    input  logic [W-1:0]  control_in,
    input  logic [GW-1:0] gear,
    output logic [W-1:0]  scaled,
    output logic          sat
);

    localparam logic [W-1:0]  POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [GW-1:0] ACQ_G   = GW'(ACQ_GEAR);

    // Select saturating doubling or arithmetic right shift by gear.
    always_comb begin
        scaled = {W{1'b0}};
        sat    = 1'b0;
        if (gear == ACQ_G) begin
            // Doubling overflows exactly when the two top bits differ.
            if (control_in[W-1] != control_in[W-2]) begin
                sat = 1'b1;
                if (control_in[W-1]) begin
                    scaled = NEG_MIN;
                end else begin
                    scaled = POS_MAX;
                end
            end else begin
                scaled = {control_in[W-2:0], 1'b0};
            end
        end else begin
            scaled = $signed(control_in) >>> gear;
        end
    end

endmodule

// File: rtl/adaptive_bw_gearshift.sv
// Dwell-qualified loop-gain gearbox between the DPLL loop filter and DCO.
// Locked valid samples climb the gear ladder one step per LOCK_DWELL run;
// UNLOCK_DWELL consecutive unlocked valid samples drop straight to gear 0.
// Each sample is scaled with the gear held before its own update.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   lock_status  raw lock indication
//   ctrl_valid   control_in holds a new sample
//   control_in   signed loop-filter sample
//   control_out  registered scaled sample (held when out_valid=0)
//   out_valid    control_out updated this cycle
//   gear         current gear
//   sat          the sample on control_out was clipped
//   gear_change  one-cycle pulse on each gear change
module adaptive_bw_gearshift
    import dpll_pkg::*;
#(
    parameter int W            = DEFAULT_W,
    parameter int GEARS        = DEFAULT_GEARS,
    parameter int LOCK_DWELL   = 8,
    parameter int UNLOCK_DWELL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lock_status,
    input  logic                     ctrl_valid,
    input  logic [W-1:0]             control_in,
    output logic [W-1:0]             control_out,
    output logic                     out_valid,
    output logic [$clog2(GEARS)-1:0] gear,
    output logic                     sat,
    output logic                     gear_change
);

    localparam int GW  = $clog2(GEARS);
    localparam int LCW = $clog2(LOCK_DWELL + 1);
    localparam int UCW = $clog2(UNLOCK_DWELL + 1);

    localparam logic [GW-1:0]  ACQ_G       = GW'(ACQ_GEAR);
    localparam logic [GW-1:0]  TOP_GEAR    = GW'(GEARS - 1);
    localparam logic [LCW-1:0] LOCK_MAX    = LCW'(LOCK_DWELL);
    localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_DWELL - 1);
    localparam logic [UCW-1:0] UNLOCK_MAX  = UCW'(UNLOCK_DWELL);
    localparam logic [UCW-1:0] UNLOCK_LAST = UCW'(UNLOCK_DWELL - 1);

    logic [GW-1:0]  gear_r,       gear_nxt_s;
    logic [LCW-1:0] lock_cnt_r,   lock_cnt_nxt_s;
    logic [UCW-1:0] unlock_cnt_r, unlock_cnt_nxt_s;
    logic           gear_change_r, gear_change_nxt_s;
    logic [W-1:0]   control_out_r;
    logic           out_valid_r;
    logic           sat_r;
    logic [W-1:0]   scaled_s;
    logic           sat_s;

    bw_sat_shift #(
        .W  (W),
        .GW (GW)
    ) u_scaler (
        .control_in (control_in),
        .gear       (gear_r),
        .scaled     (scaled_s),
        .sat        (sat_s)
    );

    // Gear ladder and dwell counters: next state from the current valid sample.
    always_comb begin
        gear_nxt_s        = gear_r;
        lock_cnt_nxt_s    = lock_cnt_r;
        unlock_cnt_nxt_s  = unlock_cnt_r;
        gear_change_nxt_s = 1'b0;
        if (ctrl_valid) begin
            if (lock_status) begin
                unlock_cnt_nxt_s = {UCW{1'b0}};
                // This sample completes the lock dwell.
                if (lock_cnt_r >= LOCK_LAST) begin
                    if (gear_r != TOP_GEAR) begin
                        gear_nxt_s        = gear_r + GW'(1);
                        lock_cnt_nxt_s    = {LCW{1'b0}};
                        gear_change_nxt_s = 1'b1;
                    end else begin
                        lock_cnt_nxt_s = LOCK_MAX;
                    end
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + LCW'(1);
                end
            end else begin
                lock_cnt_nxt_s = {LCW{1'b0}};
                // This sample completes the unlock dwell.
                if (unlock_cnt_r >= UNLOCK_LAST) begin
                    if (gear_r != ACQ_G) begin
                        gear_nxt_s        = ACQ_G;
                        unlock_cnt_nxt_s  = {UCW{1'b0}};
                        gear_change_nxt_s = 1'b1;
                    end else begin
                        unlock_cnt_nxt_s = UNLOCK_MAX;
                    end
                end else begin
                    unlock_cnt_nxt_s = unlock_cnt_r + UCW'(1);
                end
            end
        end else begin
            gear_change_nxt_s = 1'b0;
        end
    end

    // State and output registers; outputs hold while no sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gear_r        <= {GW{1'b0}};
            lock_cnt_r    <= {LCW{1'b0}};
            unlock_cnt_r  <= {UCW{1'b0}};
            gear_change_r <= 1'b0;
            control_out_r <= {W{1'b0}};
            out_valid_r   <= 1'b0;
            sat_r         <= 1'b0;
        end else begin
            gear_r        <= gear_nxt_s;
            lock_cnt_r    <= lock_cnt_nxt_s;
            unlock_cnt_r  <= unlock_cnt_nxt_s;
            gear_change_r <= gear_change_nxt_s;
            out_valid_r   <= ctrl_valid;
            if (ctrl_valid) begin
                control_out_r <= scaled_s;
                sat_r         <= sat_s;
            end else begin
                control_out_r <= control_out_r;
                sat_r         <= sat_r;
            end
        end
    end

    assign control_out = control_out_r;
    assign out_valid   = out_valid_r;
    assign gear        = gear_r;
    assign sat         = sat_r;
    assign gear_change = gear_change_r;

endmodule

// File: tb/tb_adaptive_bw_gearshift.sv
// Self-checking bench for adaptive_bw_gearshift: directed scenarios followed
// by random traffic, all compared against an integer reference model.
module tb_adaptive_bw_gearshift;

    localparam int W            = 16;
    localparam int GEARS        = 4;
    localparam int LOCK_DWELL   = 8;
    localparam int UNLOCK_DWELL = 2;

    logic          clk;
    logic          rst;
    logic          lock_status;
    logic          ctrl_valid;
    logic [W-1:0]  control_in;
    logic [W-1:0]  control_out;
    logic          out_valid;
    logic [1:0]    gear;
    logic          sat;
    logic          gear_change;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_gear, m_lcnt, m_ucnt;
    int e_out, e_sat, e_ov, e_gc;

    adaptive_bw_gearshift #(
        .W            (W),
        .GEARS        (GEARS),
        .LOCK_DWELL   (LOCK_DWELL),
        .UNLOCK_DWELL (UNLOCK_DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lock_status (lock_status),
        .ctrl_valid  (ctrl_valid),
        .control_in  (control_in),
        .control_out (control_out),
        .out_valid   (out_valid),
        .gear        (gear),
        .sat         (sat),
        .gear_change (gear_change)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gear = 0; m_lcnt = 0; m_ucnt = 0;
        e_out = 0; e_sat = 0; e_ov = 0; e_gc = 0;
    endtask

    // Sample update following the gear rules with plain integer arithmetic.
    task automatic model_step(input bit v, input bit lk, input logic [W-1:0] d);
        int x, p, q;
        e_gc = 0;
        e_ov = v ? 1 : 0;
        if (v) begin
            x = int'($signed(d));
            if (m_gear == 0) begin
                q = 2 * x;
                e_sat = 0;
                if (q > 32767) begin q = 32767; e_sat = 1; end
                if (q < -32768) begin q = -32768; e_sat = 1; end
            end else begin
                p = 1 << m_gear;
                q = x / p;
                if ((x % p != 0) && (x < 0)) q = q - 1;
                e_sat = 0;
            end
            e_out = q;
            if (lk) begin
                m_ucnt = 0;
                m_lcnt++;
                if (m_lcnt >= LOCK_DWELL) begin
                    if (m_gear < GEARS - 1) begin
                        m_gear++; m_lcnt = 0; e_gc = 1;
                    end else begin
                        m_lcnt = LOCK_DWELL;
                    end
                end
            end else begin
                m_lcnt = 0;
                m_ucnt++;
                if (m_ucnt >= UNLOCK_DWELL) begin
                    if (m_gear != 0) e_gc = 1;
                    m_gear = 0;
                    m_ucnt = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".out_valid"},   int'(out_valid), e_ov);
        check_eq({tag, ".control_out"}, int'($signed(control_out)), e_out);
        check_eq({tag, ".sat"},         int'(sat), e_sat);
        check_eq({tag, ".gear"},        int'(gear), m_gear);
        check_eq({tag, ".gear_change"}, int'(gear_change), e_gc);
    endtask

    // One clock: drive, clock it in, update the model, compare after the edge.
    task automatic step(input bit v, input bit lk, input logic [W-1:0] d, input string tag);
        ctrl_valid  = v;
        lock_status = lk;
        control_in  = d;
        @(posedge clk);
        #1;
        model_step(v, lk, d);
        compare_all(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ctrl_valid = 1'b0; lock_status = 1'b0; control_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int lock_mode;
        bit v, lk;
        logic [W-1:0] d;

        rst = 1'b1;
        ctrl_valid = 1'b0; lock_status = 1'b0; control_in = '0;
        model_reset();
        #2;
        compare_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Eight locked samples at gear 0, step on the eighth.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h0100, "acq");
        check_eq("plan_gc8", int'(gear_change), 1);
        check_eq("plan_out8", int'(control_out), 16'h0200);
        step(1'b1, 1'b1, 16'h0100, "ninth");
        check_eq("plan_ninth", int'(control_out), 16'h0080);

        // Climb to the top gear and stay.
        for (int i = 0; i < 26; i++) step(1'b1, 1'b1, 16'h0100, "climb");
        check_eq("plan_top_gear", int'(gear), 3);
        check_eq("plan_top_out", int'(control_out), 16'h0020);

        // Top gear: negative shift, glitch, then real unlock.
        step(1'b1, 1'b1, 16'hFFF1, "neg");
        check_eq("plan_neg", int'(control_out), 16'hFFFE);
        step(1'b1, 1'b0, 16'h0100, "glitch");
        check_eq("plan_glitch_gear", int'(gear), 3);
        step(1'b1, 1'b1, 16'h0100, "relock");
        step(1'b1, 1'b0, 16'h0100, "unlock1");
        step(1'b1, 1'b0, 16'h0100, "unlock2");
        check_eq("plan_drop_gear", int'(gear), 0);
        check_eq("plan_drop_gc", int'(gear_change), 1);
        check_eq("plan_drop_out", int'(control_out), 16'h0020);

        // Saturation at gear 0.
        step(1'b1, 1'b0, 16'h5000, "sat_pos");
        check_eq("plan_sat_pos", int'(control_out), 16'h7FFF);
        check_eq("plan_sat_pos_flag", int'(sat), 1);
        step(1'b1, 1'b0, 16'hA000, "sat_neg");
        check_eq("plan_sat_neg", int'(control_out), 16'h8000);
        step(1'b1, 1'b0, 16'h3FFF, "nosat");
        check_eq("plan_nosat", int'(control_out), 16'h7FFE);
        check_eq("plan_nosat_flag", int'(sat), 0);

        // Valid gaps: step only after eight valid samples.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step((i % 2) == 0, 1'b1, 16'h0100, "gaps");
            if (i == 13) check_eq("plan_gap_hold", int'(gear), 0);
        end
        check_eq("plan_gap_gear", int'(gear), 1);

        // Asynchronous reset at gear 2 with lock_cnt=5.
        apply_reset();
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 16'h0123, "pre_rst");
        check_eq("plan_pre_rst_gear", int'(gear), 2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 16'h0100, "post_rst");
        check_eq("plan_post_rst7", int'(gear), 0);
        step(1'b1, 1'b1, 16'h0100, "post_rst8");
        check_eq("plan_post_rst8", int'(gear), 1);

        // Random traffic with long lock/unlock phases and short glitches.
        lock_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) lock_mode = 1 - lock_mode;
            v  = ($urandom_range(0, 3) != 0);
            lk = (lock_mode == 1) ? ($urandom_range(0, 14) != 0) : ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                default: d = W'($urandom());
            endcase
            step(v, lk, d, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
